// File: rtl/qseq_pkg.sv
// qseq_pkg: shared types and helpers for the q-flop bank sequencer
package qseq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, CAPTURE} qseq_state_t;
  localparam int QSEQ_STATE_W = 2;
  // Minimum STROBE length: a stale ack needs SYNC_STAGES+1 cycles to be flushed
  function automatic int qseq_blank_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction
endpackage

// File: rtl/qseq_ack_sync.sv
// qseq_ack_sync: WIDTH x STAGES synchronizer for the asynchronous q-flop acks
//   clock, reset  : system clock, async active-high reset
//   i_async       : raw per-element acks
//   o_sync        : synchronized acks
module qseq_ack_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);
  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_async};
  assign o_sync = r_sync[STAGES-1];
endmodule

// File: rtl/qflop_bank_sequencer.sv
// qflop_bank_sequencer: sequences a self-timed q-flop bank between valid/ready stages
//   clock, reset         : system clock, async active-high reset
//   in_valid/in_ready/in_data    : upstream word
//   qf_data, qf_clock    : registered data and shared strobe to the bank
//   qf_ack, qf_out       : asynchronous settled flags and resolved outputs
//   out_valid/out_ready/out_data : captured word
//   busy                 : FSM not idle
//   timeout_err          : sticky strobe timeout, present only with QSEQ_TIMEOUT_EN
module qflop_bank_sequencer
  import qseq_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] qf_data,
  output logic             qf_clock,
  input  logic [WIDTH-1:0] qf_ack,
  input  logic [WIDTH-1:0] qf_out,
`ifdef QSEQ_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int BLANK   = qseq_blank_cycles(SYNC_STAGES);
  localparam int M1      = SETUP_CYCLES > BLANK ? SETUP_CYCLES : BLANK;
  localparam int CNT_MAX = TIMEOUT > M1 ? TIMEOUT : M1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  qseq_state_t      r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_ack_sync, r_qf_data, r_out_data;
  logic             w_all_ack, w_load, w_capture, r_qf_clock, r_out_valid;
`ifdef QSEQ_TIMEOUT_EN
  logic             w_tmo, r_timeout_err;
`endif

  qseq_ack_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset  (reset),
    .i_async(qf_ack),
    .o_sync (w_ack_sync)
  );

  assign w_all_ack = &w_ack_sync;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_capture   = 1'b0;
`ifdef QSEQ_TIMEOUT_EN
    w_tmo       = 1'b0;
`endif
    case (r_state)
      IDLE:
        if (in_valid) begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
      SETUP:
        if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt + CW'(1);
      STROBE:
        // acks are only trusted once a stale high has had time to flush
        if (w_all_ack && r_cnt >= CW'(BLANK - 1)) begin
          w_state_nxt = CAPTURE;
          w_cnt_nxt   = '0;
        end
`ifdef QSEQ_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt = CAPTURE;
          w_cnt_nxt   = '0;
          w_tmo       = 1'b1;
        end
`endif
        else if (r_cnt != CW'(CNT_MAX)) w_cnt_nxt = r_cnt + CW'(1);
      CAPTURE:
        if (!r_out_valid || out_ready) begin
          w_state_nxt = IDLE;
          w_capture   = 1'b1;
        end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_qf_clock  <= 1'b0;
      r_qf_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // strobe is a flop decoded from next state, so it never glitches
      r_qf_clock <= (w_state_nxt == STROBE);
      if (w_load) r_qf_data <= in_data;
      if (w_capture) begin
        r_out_data  <= qf_out;
        r_out_valid <= 1'b1;
      end else if (out_ready) r_out_valid <= 1'b0;
    end

`ifdef QSEQ_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset)      r_timeout_err <= 1'b0;
    else if (w_tmo) r_timeout_err <= 1'b1;
  assign timeout_err = r_timeout_err;
`endif

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign qf_data   = r_qf_data;
  assign qf_clock  = r_qf_clock;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
endmodule
